// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, state encoding and datapath select encodings for multi_cycle_control
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC_R  = 4'd2,
    ST_EXEC_I  = 4'd3,
    ST_ADDR    = 4'd4,
    ST_MEM_RD  = 4'd5,
    ST_MEM_WR  = 4'd6,
    ST_WB_ALU  = 4'd7,
    ST_WB_MEM  = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JUMP    = 4'd10,
    ST_TRAP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // States that issue a memory request and therefore run the wait counter.
  function automatic logic is_mem_state(state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// rtl/mc_wait_counter.sv - counts stalled memory cycles and flags the one that exhausts MEM_TIMEOUT
module mc_wait_counter #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires on the stalled cycle that brings the count to MEM_TIMEOUT; a ready cycle never counts.
  assign timeout = waiting && (count == LAST_WAIT);

endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle MIPS-style control FSM; MULTI_CYCLE_CONTROL_JUMP_EN enables the j instruction
module multi_cycle_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUOP_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               alu_res_msb,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_wr,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic               reg_wr,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               ext_op,
  output logic               alu_src_a,
  output logic               npc_sel,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               error,
  output logic [3:0]         state_o
);

  state_t     state, state_next;
  logic       error_q;
  logic       timeout;
  logic       branch_taken;
  logic       mem_req_m, mem_wr_m, ir_wr_m, pc_wr_m, reg_wr_m;
  logic [1:0] alu_op_m;

  mc_wait_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .clear   (is_mem_state(state_next) && (state_next != state)),
    .waiting (mem_req_m && !mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      error_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == ST_TRAP) error_q <= 1'b1;
    end
  end

  always_comb begin
    case (opcode)
      OP_BEQ:  branch_taken = zero;
      OP_BNE:  branch_taken = !zero;
      OP_BGTZ: branch_taken = !zero && !alu_res_msb;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  if (mem_ready) state_next = ST_DECODE; else if (timeout) state_next = ST_TRAP;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                 state_next = ST_EXEC_R;
          OP_ADDI:                  state_next = ST_EXEC_I;
          OP_LW, OP_SW:             state_next = ST_ADDR;
          OP_BEQ, OP_BNE, OP_BGTZ:  state_next = ST_BRANCH;
`ifdef MULTI_CYCLE_CONTROL_JUMP_EN
          OP_J:                     state_next = ST_JUMP;
`endif
          default:                  state_next = ST_TRAP;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_next = ST_WB_ALU;
      ST_ADDR:   state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: if (mem_ready) state_next = ST_WB_MEM; else if (timeout) state_next = ST_TRAP;
      ST_MEM_WR: if (mem_ready) state_next = ST_FETCH; else if (timeout) state_next = ST_TRAP;
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_next = ST_FETCH;
      ST_TRAP:   state_next = ST_TRAP;
      default:   state_next = ST_TRAP;
    endcase
  end

  always_comb begin
    mem_req_m  = 1'b0;
    mem_wr_m   = 1'b0;
    ir_wr_m    = 1'b0;
    pc_wr_m    = 1'b0;
    reg_wr_m   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 1'b0;
    alu_src_a  = 1'b0;
    npc_sel    = 1'b0;
    alu_src_b  = SRC_B_RT;
    alu_op_m   = ALU_ADD;
    case (state)
      ST_FETCH: begin
        mem_req_m = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_wr_m   = mem_ready;
        pc_wr_m   = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        ext_op    = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op_m  = ALU_FUNCT;
      end
      ST_EXEC_I, ST_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        ext_op    = 1'b1;
      end
      ST_MEM_RD: mem_req_m = 1'b1;
      ST_MEM_WR: begin
        mem_req_m = 1'b1;
        mem_wr_m  = 1'b1;
      end
      // Destination register is rd only for R-type; the IR still holds the opcode here.
      ST_WB_ALU: begin
        reg_wr_m = 1'b1;
        reg_dst  = (opcode == OP_RTYPE);
      end
      ST_WB_MEM: begin
        reg_wr_m   = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op_m  = ALU_SUB;
        npc_sel   = 1'b1;
        pc_wr_m   = branch_taken;
      end
      ST_JUMP: begin
        pc_wr_m   = 1'b1;
        npc_sel   = 1'b1;
        alu_src_b = SRC_B_IMM_SH2;
      end
      default: ;
    endcase
  end

  assign mem_req = mem_req_m && !reset;
  assign mem_wr  = mem_wr_m  && !reset;
  assign ir_wr   = ir_wr_m   && !reset;
  assign pc_wr   = pc_wr_m   && !reset;
  assign reg_wr  = reg_wr_m  && !reset;
  assign alu_op  = ALUOP_W'(alu_op_m);
  assign error   = error_q;
  assign state_o = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - randomized scoreboard bench for multi_cycle_control
module tb_multi_cycle_control;
  import mc_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_wr, ir_wr, pc_wr, reg_wr;
    logic       reg_dst, mem_to_reg, ext_op, alu_src_a, npc_sel;
    logic [1:0] src_b;
    logic [1:0] aop;
    logic       error;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset, zero, alu_res_msb, mem_ready;
  logic [5:0] opcode;
  logic       mem_req, mem_wr, ir_wr, pc_wr, reg_wr, reg_dst, mem_to_reg, ext_op, alu_src_a, npc_sel, error;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state_o;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic z_v, m_v;

  multi_cycle_control #(.MEM_TIMEOUT(TO), .ALUOP_W(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .alu_res_msb(alu_res_msb),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_wr(mem_wr), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .ext_op(ext_op),
    .alu_src_a(alu_src_a), .npc_sel(npc_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .error(error), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle spent in phase p, straight from the per-state output table.
  function automatic obs_t model(state_t p, logic [5:0] op, logic mr, logic z, logic m, logic rst);
    obs_t r = '0;
    r.st = p;
    case (p)
      ST_FETCH:  begin r.mem_req = 1; r.src_b = 2'b01; r.ir_wr = mr; r.pc_wr = mr; end
      ST_DECODE: begin r.src_b = 2'b11; r.ext_op = 1; end
      ST_EXEC_R: begin r.alu_src_a = 1; r.aop = 2'b10; end
      ST_EXEC_I, ST_ADDR: begin r.alu_src_a = 1; r.src_b = 2'b10; r.ext_op = 1; end
      ST_MEM_RD: r.mem_req = 1;
      ST_MEM_WR: begin r.mem_req = 1; r.mem_wr = 1; end
      ST_WB_ALU: begin r.reg_wr = 1; r.reg_dst = (op == 6'b000000); end
      ST_WB_MEM: begin r.reg_wr = 1; r.mem_to_reg = 1; end
      ST_BRANCH: begin
        r.alu_src_a = 1; r.aop = 2'b01; r.npc_sel = 1;
        r.pc_wr = (op == 6'b000100) ? z : (op == 6'b000101) ? !z : (!z && !m);
      end
      ST_JUMP:   begin r.pc_wr = 1; r.npc_sel = 1; r.src_b = 2'b11; end
      ST_TRAP:   r.error = 1;
      default: ;
    endcase
    if (rst) begin
      r.mem_req = 0; r.mem_wr = 0; r.ir_wr = 0; r.pc_wr = 0; r.reg_wr = 0;
    end
    return r;
  endfunction

  task automatic step(state_t p, logic [5:0] op, logic mr, logic rst);
    @(posedge clk); #1;
    opcode = op; zero = z_v; alu_res_msb = m_v; mem_ready = mr; reset = rst;
    exp_q.push_back(model(p, op, mr, z_v, m_v, rst));
  endtask

  task automatic trap_seq(logic [5:0] op);
    int n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) step(ST_TRAP, op, 1'($urandom_range(0, 1)), 1'b0);
    step(ST_TRAP, op, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // Memory phase: `waits` stalled cycles then ready, or a trap once TO stalls accumulate.
  task automatic mem_wait(state_t p, logic [5:0] op, int waits, output bit ok);
    ok = 0;
    for (int k = 0; k < TO; k++) begin
      step(p, op, 1'(k == waits), 1'b0);
      if (k == waits) begin ok = 1; return; end
    end
    trap_seq(op);
  endtask

  task automatic run_instr(logic [5:0] op, int wf, int wm, bit rst_in_mem);
    bit ok;
    mem_wait(ST_FETCH, op, wf, ok);
    if (!ok) return;
    step(ST_DECODE, op, 1'($urandom_range(0, 1)), 1'b0);
    case (op)
      6'b000000: begin step(ST_EXEC_R, op, 1'($urandom_range(0, 1)), 0); step(ST_WB_ALU, op, 1'($urandom_range(0, 1)), 0); end
      6'b001000: begin step(ST_EXEC_I, op, 1'($urandom_range(0, 1)), 0); step(ST_WB_ALU, op, 1'($urandom_range(0, 1)), 0); end
      6'b100011: begin
        step(ST_ADDR, op, 1'($urandom_range(0, 1)), 0);
        if (rst_in_mem) begin
          for (int k = 0; k < wm; k++) step(ST_MEM_RD, op, 1'b0, 1'b0);
          step(ST_MEM_RD, op, 1'b0, 1'b1);
        end else begin
          mem_wait(ST_MEM_RD, op, wm, ok);
          if (ok) step(ST_WB_MEM, op, 1'($urandom_range(0, 1)), 0);
        end
      end
      6'b101011: begin
        step(ST_ADDR, op, 1'($urandom_range(0, 1)), 0);
        mem_wait(ST_MEM_WR, op, wm, ok);
      end
      6'b000100, 6'b000101, 6'b000111: step(ST_BRANCH, op, 1'($urandom_range(0, 1)), 0);
`ifdef MULTI_CYCLE_CONTROL_JUMP_EN
      6'b000010: step(ST_JUMP, op, 1'($urandom_range(0, 1)), 0);
`endif
      default: trap_seq(op);
    endcase
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = {state_o, mem_req, mem_wr, ir_wr, pc_wr, reg_wr, reg_dst, mem_to_reg,
           ext_op, alu_src_a, npc_sel, alu_src_b, alu_op, error};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t state=%0d actual=%b required=%b", $time, e.st, a, e);
      end
    end
  end

  initial begin
    logic [5:0] ops [9];
    reset = 1; opcode = 0; zero = 0; alu_res_msb = 0; mem_ready = 0; z_v = 0; m_v = 0;
    repeat (3) @(posedge clk);
    step(ST_FETCH, 6'b000000, 1'b1, 1'b1);

    // Directed cases first.
    run_instr(OP_LW, 0, 0, 0);
    z_v = 1; m_v = 0; run_instr(OP_BEQ, 0, 0, 0);
    z_v = 0; m_v = 1; run_instr(OP_BGTZ, 0, 0, 0);
    z_v = 0; m_v = 0; run_instr(OP_BNE, 0, 0, 0);
    run_instr(OP_SW, 0, 3, 0);
    run_instr(OP_RTYPE, 3, 0, 0);
    run_instr(OP_ADDI, 9, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    run_instr(OP_J, 0, 0, 0);
    run_instr(OP_LW, 1, 3, 1);

    ops = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGTZ, OP_J, 6'b000000};
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op;
      int idx, wf, wm;
      bit rim;
      idx = $urandom_range(0, 8);
      op  = (idx == 8) ? 6'($urandom_range(0, 63)) : ops[idx];
      wf  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
      wm  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
      rim = (op == OP_LW) && ($urandom_range(0, 5) == 0);
      if (rim) wm = $urandom_range(1, TO - 1);
      z_v = 1'($urandom_range(0, 1));
      m_v = 1'($urandom_range(0, 1));
      run_instr(op, wf, wm, rim);
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles a memory request waits for mem_ready before trap; legal range 1..255.
REQ-002 Parameter ALUOP_W, default 2: width of alu_op.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 opcode  in  6  instruction[31:26], sampled from the instruction register.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 alu_res_msb  in  1  ALU result bit 31.
REQ-009 mem_ready  in  1  memory accepts/completes the current request this cycle.
REQ-010 mem_req, mem_wr  out  1 each  memory request; write qualifier.
REQ-011 ir_wr, pc_wr, reg_wr  out  1 each  instruction-register, PC and register-file write strobes.
REQ-012 reg_dst, mem_to_reg, ext_op, alu_src_a, npc_sel  out  1 each  datapath selects.
REQ-013 alu_src_b  out  2  operand B select: 00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-014 alu_op  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded.
REQ-015 error  out  1  sticky trap flag.
REQ-016 state_o  out  4  current state encoding, for debug.

Function
REQ-017 States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
REQ-018 FETCH: mem_req=1, alu_src_a=0, alu_src_b=01, alu_op=00; ir_wr and pc_wr asserted only in the cycle mem_ready=1, then go to DECODE; otherwise hold.
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, alu_op=00 (branch target); next state by opcode: 000000->EXEC_R, 001000->EXEC_I, 100011/101011->ADDR, 000100/000101/000111->BRANCH, 000010->JUMP (JUMP_EN only), any other->TRAP.
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU with reg_dst=1. EXEC_I: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00 -> WB_ALU with reg_dst=0.
REQ-021 WB_ALU: reg_wr=1, mem_to_reg=0 -> FETCH. WB_MEM: reg_wr=1, reg_dst=0, mem_to_reg=1 -> FETCH.
REQ-022 ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00 -> MEM_RD (lw) or MEM_WR (sw).
REQ-023 MEM_RD: mem_req=1, mem_wr=0; on mem_ready -> WB_MEM. MEM_WR: mem_req=1, mem_wr=1; on mem_ready -> FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, npc_sel=1; pc_wr=1 iff taken: beq zero; bne !zero; bgtz !zero && !alu_res_msb; -> FETCH always.
REQ-025 Latency with zero-wait memory: R-type/addi/sw 4 cycles, lw 5, branch 3, jump 3.
REQ-026 Wait counter clears on every entry to FETCH/MEM_RD/MEM_WR, increments each cycle mem_req=1 and mem_ready=0; reaching MEM_TIMEOUT -> TRAP.
REQ-027 mem_ready in the same cycle the counter reaches MEM_TIMEOUT wins: normal transition, no trap.
REQ-028 TRAP: every strobe 0, error=1, state held until reset.
REQ-029 mem_ready outside a memory state is ignored.
REQ-030 All outputs except pc_wr/ir_wr are Moore functions of state; unlisted outputs are 0 in each state.

Reset
REQ-031 reset sampled high at an edge: state=FETCH, counter=0, error=0, from any state including mid-wait and TRAP.
REQ-032 While reset is high all strobes (mem_req, ir_wr, pc_wr, reg_wr, mem_wr) are forced 0.

Configuration
REQ-033 Macro MULTI_CYCLE_CONTROL_JUMP_EN: defined -> opcode 000010 goes to JUMP (pc_wr=1, npc_sel=1, alu_src_b=11) then FETCH; undefined -> 000010 is illegal and goes to TRAP.

Structure
REQ-034 Package mc_pkg holds opcode constants, state enum, alu_op and alu_src_b encodings.
REQ-035 Sub-module mc_wait_counter (parametrised by MEM_TIMEOUT, $clog2(MEM_TIMEOUT+1) bits) implements REQ-026/027.

Verification
REQ-036 lw, mem_ready constant 1 -> FETCH,DECODE,ADDR,MEM_RD,WB_MEM; reg_wr=1 and mem_to_reg=1 in cycle 5.
REQ-037 beq zero=1 -> pc_wr=1 in BRANCH; bgtz zero=0 msb=1 -> pc_wr=0; bne zero=0 -> pc_wr=1.
REQ-038 sw with mem_ready low 3 cycles then high -> MEM_WR held 4 cycles, mem_wr=1 throughout, then FETCH.
REQ-039 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles, error=1; reset -> FETCH, error=0.
REQ-040 opcode 111111 -> TRAP after DECODE; opcode 000010 -> JUMP with macro defined, TRAP without.
REQ-041 reset asserted in MEM_RD wait -> next state FETCH, reg_wr never asserted.
